// File: rtl/imem_wb_loader.sv
// imem_wb_loader
//   Wishbone slave that programs and reads back the SLRV instruction SRAM
//   through SRAM port 0. It also holds the SLRV core in reset until
//   software sets the run bit. The core keeps fetching on SRAM port 1,
//   which this block does not touch.
//
//   Address map (offsets from BASE_ADDR, decoded on adr[31:12]):
//     adr[11]=0 : memory window, word index = adr[ADDR_W+1:2]
//     0x800 CTRL   : bit0 run (R/W), bit1 clr (write-1, reads 0)
//     0x804 STATUS : [CNT_W-1:0] write count, bit16 wr_blocked, bit17 run
//     0x808 CSUM   : wrapping sum of written data (optional feature)
//
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//     defined     -> 0x808 returns the sum of (dat & byte-mask) over all
//                    issued SRAM writes, cleared by reset and by clr
//     not defined -> 0x808 reads 0, no checksum logic is built
//
//   Ports:
//     wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//     wbs_*                      Wishbone slave interface
//     sram_csb0/web0/wmask0/addr0/din0, sram_dout0
//                                SRAM port 0 (active-low strobes)
//     core_rst_o                 core reset, high while run=0
module imem_wb_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_W    = 9,
  parameter int          CNT_W     = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [3:0]        sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [31:0]       sram_din0,
  input  logic [31:0]       sram_dout0,
  output logic              core_rst_o
);

  typedef enum logic [2:0] {IDLE, MEM_WR, MEM_RD, RD_WAIT, ACK} state_t;

  localparam logic [9:0] OFF_CTRL   = 10'h200;
  localparam logic [9:0] OFF_STATUS = 10'h201;
  localparam logic [9:0] OFF_CSUM   = 10'h202;

  state_t              state_q, state_d;
  logic [31:0]         dat_q, dat_d;
  logic                csb_q, csb_d;
  logic                web_q, web_d;
  logic [3:0]          wmask_q, wmask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic                run_q, run_d;
  logic                core_rst_q, core_rst_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wr_blocked_q, wr_blocked_d;
  // A control write is held until the ACK cycle and applied there, so clr
  // and run changes become visible in the cycle after the ack.
  logic                ctl_wr_q, ctl_wr_d;
  logic                ctl_run_q, ctl_run_d;
  logic                ctl_clr_q, ctl_clr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;
  logic [31:0]         wmask_bits;
`endif

  logic                req_valid;
  logic [9:0]          reg_off;
  logic [31:0]         reg_rdata;
  logic                unused_adr;

  assign req_valid  = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign reg_off    = wbs_adr_i[11:2];
  assign unused_adr = ^wbs_adr_i[1:0];

  assign wbs_ack_o   = (state_q == ACK);
  assign wbs_dat_o   = dat_q;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;
  assign core_rst_o  = core_rst_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign wmask_bits = {{8{wmask_q[3]}}, {8{wmask_q[2]}}, {8{wmask_q[1]}}, {8{wmask_q[0]}}};
`endif

  // Control/status read mux; clr is write-only and always reads back 0.
  always_comb begin
    reg_rdata = '0;
    case (reg_off)
      OFF_CTRL:   reg_rdata[0] = run_q;
      OFF_STATUS: begin
        reg_rdata[CNT_W-1:0] = count_q;
        reg_rdata[16]        = wr_blocked_q;
        reg_rdata[17]        = run_q;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      OFF_CSUM:   reg_rdata = csum_q;
`endif
      default:    reg_rdata = '0;
    endcase
  end

  // Next-state and output logic. SRAM strobes default to idle, so csb0 is
  // low only in MEM_WR/MEM_RD, one cycle per access; address/data/mask hold.
  always_comb begin
    state_d      = state_q;
    dat_d        = '0;
    csb_d        = 1'b1;
    web_d        = 1'b1;
    wmask_d      = wmask_q;
    addr_d       = addr_q;
    din_d        = din_q;
    run_d        = run_q;
    core_rst_d   = ~run_q;
    count_d      = count_q;
    wr_blocked_d = wr_blocked_q;
    ctl_wr_d     = ctl_wr_q;
    ctl_run_d    = ctl_run_q;
    ctl_clr_d    = ctl_clr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!wbs_adr_i[11]) begin
            if (wbs_we_i) begin
              if (run_q) begin
                wr_blocked_d = 1'b1;
                state_d      = ACK;
              end else if (wbs_sel_i == 4'b0000) begin
                state_d = ACK;
              end else begin
                state_d = MEM_WR;
                csb_d   = 1'b0;
                web_d   = 1'b0;
                wmask_d = wbs_sel_i;
                addr_d  = wbs_adr_i[ADDR_W+1:2];
                din_d   = wbs_dat_i;
              end
            end else begin
              state_d = MEM_RD;
              csb_d   = 1'b0;
              addr_d  = wbs_adr_i[ADDR_W+1:2];
            end
          end else begin
            state_d = ACK;
            if (wbs_we_i) begin
              ctl_wr_d  = (reg_off == OFF_CTRL);
              ctl_run_d = wbs_dat_i[0];
              ctl_clr_d = wbs_dat_i[1];
            end else begin
              dat_d = reg_rdata;
            end
          end
        end
      end
      // The write is on the SRAM pins this cycle, so it counts even if the
      // master aborts now.
      MEM_WR: begin
        if (count_q != {CNT_W{1'b1}}) begin
          count_d = count_q + CNT_W'(1);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q + (din_q & wmask_bits);
`endif
        state_d = wbs_cyc_i ? ACK : IDLE;
      end
      MEM_RD: begin
        state_d = wbs_cyc_i ? RD_WAIT : IDLE;
      end
      RD_WAIT: begin
        if (wbs_cyc_i) begin
          state_d = ACK;
          dat_d   = sram_dout0;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        state_d  = IDLE;
        ctl_wr_d = 1'b0;
        if (ctl_wr_q) begin
          run_d = ctl_run_q;
          if (ctl_clr_q) begin
            count_d      = '0;
            wr_blocked_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d       = '0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      dat_q        <= '0;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      wmask_q      <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      run_q        <= 1'b0;
      core_rst_q   <= 1'b1;
      count_q      <= '0;
      wr_blocked_q <= 1'b0;
      ctl_wr_q     <= 1'b0;
      ctl_run_q    <= 1'b0;
      ctl_clr_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dat_q        <= dat_d;
      csb_q        <= csb_d;
      web_q        <= web_d;
      wmask_q      <= wmask_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      run_q        <= run_d;
      core_rst_q   <= core_rst_d;
      count_q      <= count_d;
      wr_blocked_q <= wr_blocked_d;
      ctl_wr_q     <= ctl_wr_d;
      ctl_run_q    <= ctl_run_d;
      ctl_clr_q    <= ctl_clr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_wb_loader.sv
// tb_imem_wb_loader
//   Directed bench for imem_wb_loader with a behavioural 512x32 SRAM model
//   on port 0. Bus transfers report ack latency, SRAM strobe activity and
//   read data; each result is compared against hand-computed values.
module tb_imem_wb_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_dat_i = '0;
  logic [31:0] wbs_adr_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;
  logic        core_rst_o;

  logic [31:0] mem [512];

  int          check_count = 0;
  int          pass_count  = 0;
  int          csb_pulses;
  logic [8:0]  last_addr;
  logic        last_web;
  logic [3:0]  last_wmask;
  logic [31:0] last_din;
  logic [31:0] post_dat;
  logic [31:0] rdata;
  int          lat;
  logic        got_ack;

  imem_wb_loader dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_wmask0(sram_wmask0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .core_rst_o (core_rst_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Port-0 SRAM model: one-cycle read latency, byte-masked writes.
  always @(posedge wb_clk_i) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
        end
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One Wishbone transfer; lat is the number of cycles from the request
  // cycle to the ack cycle, or -1 if no ack came within the budget.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, output logic [31:0] rd, output int lt);
    lt = -1;
    rd = '0;
    csb_pulses = 0;
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    for (int i = 1; i <= 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (!sram_csb0) begin
        csb_pulses++;
        last_addr  = sram_addr0;
        last_web   = sram_web0;
        last_wmask = sram_wmask0;
        last_din   = sram_din0;
      end
      if (wbs_ack_o) begin
        lt = i;
        rd = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    @(posedge wb_clk_i); #1;
    post_dat = wbs_dat_o;
    if (!sram_csb0) csb_pulses++;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;

    repeat (3) @(posedge wb_clk_i);
    #1;
    checkOutput("rst_ack", wbs_ack_o, 0);
    checkOutput("rst_dat", wbs_dat_o, 0);
    checkOutput("rst_csb", sram_csb0, 1);
    checkOutput("rst_web", sram_web0, 1);
    checkOutput("rst_wmask", sram_wmask0, 0);
    checkOutput("rst_addr", sram_addr0, 0);
    checkOutput("rst_din", sram_din0, 0);
    checkOutput("rst_core", core_rst_o, 1);
    wb_rst_i = 1'b0;

    applyStimulus(0, BASE + 32'h804, '0, 4'hF, rdata, lat);
    checkOutput("status0_lat", lat, 1);
    checkOutput("status0_dat", rdata, 32'h0);
    checkOutput("status0_csb", csb_pulses, 0);

    applyStimulus(1, BASE + 32'h010, 32'hDEADBEEF, 4'hF, rdata, lat);
    checkOutput("wr1_lat", lat, 2);
    checkOutput("wr1_pulses", csb_pulses, 1);
    checkOutput("wr1_addr", last_addr, 4);
    checkOutput("wr1_web", last_web, 0);
    checkOutput("wr1_wmask", last_wmask, 4'hF);
    checkOutput("wr1_dat_zero", rdata, 0);

    applyStimulus(0, BASE + 32'h010, '0, 4'hF, rdata, lat);
    checkOutput("rd1_lat", lat, 3);
    checkOutput("rd1_dat", rdata, 32'hDEADBEEF);
    checkOutput("rd1_pulses", csb_pulses, 1);
    checkOutput("rd1_web", last_web, 1);
    checkOutput("rd1_dat_after", post_dat, 0);

    applyStimulus(0, BASE + 32'h804, '0, 4'hF, rdata, lat);
    checkOutput("status1", rdata, 32'h0000_0001);

    applyStimulus(1, BASE + 32'h014, 32'hCAFEF00D, 4'b0011, rdata, lat);
    checkOutput("wr2_lat", lat, 2);
    checkOutput("wr2_wmask", last_wmask, 4'b0011);
    checkOutput("wr2_addr", last_addr, 5);
    checkOutput("wr2_din", last_din, 32'hCAFEF00D);
    applyStimulus(0, BASE + 32'h014, '0, 4'hF, rdata, lat);
    checkOutput("rd2_dat", rdata, 32'h0000F00D);

    applyStimulus(1, BASE + 32'h018, 32'h11111111, 4'b0000, rdata, lat);
    checkOutput("sel0_lat", lat, 1);
    checkOutput("sel0_pulses", csb_pulses, 0);
    applyStimulus(0, BASE + 32'h804, '0, 4'hF, rdata, lat);
    checkOutput("status2", rdata, 32'h0000_0002);

    applyStimulus(1, BASE + 32'h800, 32'h1, 4'hF, rdata, lat);
    checkOutput("ctrl_run_lat", lat, 1);
    repeat (2) @(posedge wb_clk_i);
    #1;
    checkOutput("core_rst_run", core_rst_o, 0);
    applyStimulus(0, BASE + 32'h800, '0, 4'hF, rdata, lat);
    checkOutput("ctrl_rd", rdata, 32'h1);

    applyStimulus(1, BASE + 32'h020, 32'h55555555, 4'hF, rdata, lat);
    checkOutput("blk_lat", lat, 1);
    checkOutput("blk_pulses", csb_pulses, 0);
    applyStimulus(0, BASE + 32'h804, '0, 4'hF, rdata, lat);
    checkOutput("status_blk", rdata, 32'h0003_0002);
    applyStimulus(0, BASE + 32'h010, '0, 4'hF, rdata, lat);
    checkOutput("rd_run_dat", rdata, 32'hDEADBEEF);

    applyStimulus(1, BASE + 32'h800, 32'h3, 4'hF, rdata, lat);
    applyStimulus(0, BASE + 32'h804, '0, 4'hF, rdata, lat);
    checkOutput("status_clr", rdata, 32'h0002_0000);
    checkOutput("core_rst_clr", core_rst_o, 0);

    applyStimulus(1, BASE + 32'h80C, 32'hFFFFFFFF, 4'hF, rdata, lat);
    checkOutput("other_wr_lat", lat, 1);
    applyStimulus(0, BASE + 32'h80C, '0, 4'hF, rdata, lat);
    checkOutput("other_rd", rdata, 0);

    applyStimulus(1, 32'h4000_0010, 32'h12345678, 4'hF, rdata, lat);
    checkOutput("nomatch_lat", lat, 32'hFFFF_FFFF);
    checkOutput("nomatch_pulses", csb_pulses, 0);

    // Stop the core (clr as well), then exercise the checksum register.
    applyStimulus(1, BASE + 32'h800, 32'h2, 4'hF, rdata, lat);
    repeat (2) @(posedge wb_clk_i);
    #1;
    checkOutput("core_rst_stop", core_rst_o, 1);
    applyStimulus(1, BASE + 32'h030, 32'h00000001, 4'hF, rdata, lat);
    applyStimulus(1, BASE + 32'h034, 32'hFFFFFFFF, 4'hF, rdata, lat);
    applyStimulus(0, BASE + 32'h808, '0, 4'hF, rdata, lat);
    checkOutput("csum_wrap", rdata, 32'h0);
    applyStimulus(1, BASE + 32'h038, 32'h12345678, 4'b0001, rdata, lat);
    applyStimulus(0, BASE + 32'h808, '0, 4'hF, rdata, lat);
`ifdef IMEM_LOADER_CHECKSUM_EN
    checkOutput("csum_byte", rdata, 32'h0000_0078);
`else
    checkOutput("csum_off", rdata, 32'h0);
`endif
    applyStimulus(0, BASE + 32'h038, '0, 4'hF, rdata, lat);
    checkOutput("rd3_dat", rdata, 32'h0000_0078);
    applyStimulus(0, BASE + 32'h804, '0, 4'hF, rdata, lat);
    checkOutput("status3", rdata, 32'h0000_0003);

    // Abort a read while the SRAM read is on the pins.
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = BASE + 32'h010; wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    checkOutput("abort_csb", sram_csb0, 0);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    got_ack = 1'b0;
    repeat (4) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) got_ack = 1'b1;
    end
    checkOutput("abort_no_ack", got_ack, 0);
    applyStimulus(0, BASE + 32'h804, '0, 4'hF, rdata, lat);
    checkOutput("abort_idle_lat", lat, 1);

    // Reset asserted while a write is in MEM_WR.
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = BASE + 32'h03C; wbs_dat_i = 32'hA5A5A5A5; wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    checkOutput("rstwr_csb_before", sram_csb0, 0);
    wb_rst_i = 1'b1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
    checkOutput("rstwr_csb_after", sram_csb0, 1);
    checkOutput("rstwr_ack", wbs_ack_o, 0);
    checkOutput("rstwr_addr", sram_addr0, 0);
    wb_rst_i = 1'b0;
    got_ack = 1'b0;
    repeat (3) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) got_ack = 1'b1;
    end
    checkOutput("rstwr_no_ack", got_ack, 0);
    applyStimulus(0, BASE + 32'h804, '0, 4'hF, rdata, lat);
    checkOutput("rstwr_status", rdata, 32'h0);
    checkOutput("rstwr_core", core_rst_o, 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
